// File: rtl/trade_order_ctrl.sv
// trade_order_ctrl: turns single-cycle buy/sell signals into valid/ready order
// transactions, enforcing a net-position limit, a post-order cooldown and an
// acknowledge timeout, and keeps saturating fill/timeout/conflict statistics.
module trade_order_ctrl #(
  parameter int MAX_POS         = 4,
  parameter int COOLDOWN_CYCLES = 8,
  parameter int TIMEOUT_CYCLES  = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       buy_signal,
  input  logic       sell_signal,
  input  logic [7:0] price,
  input  logic       order_ready,
  output logic       order_valid,
  output logic       order_side,
  output logic [7:0] order_price,
  output logic [7:0] position,
  output logic       busy,
  output logic [7:0] fill_count,
  output logic [7:0] timeout_count,
  output logic [7:0] conflict_count
);

  typedef enum logic [1:0] {IDLE, SEND, COOLDOWN} state_t;

  localparam logic signed [7:0] POS_MAX = 8'(MAX_POS);
  localparam logic signed [7:0] POS_MIN = -POS_MAX;
  localparam logic [7:0]        T_LAST  = 8'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0]        CD_LAST = 8'(COOLDOWN_CYCLES - 1);

  state_t            state_q, state_d;
  logic              side_q;
  logic [7:0]        price_q;
  logic signed [7:0] pos_q;
  logic [7:0]        wait_q;
  logic [7:0]        cd_q;
  logic [7:0]        fill_q, timeout_q, conflict_q;

  logic accept, accept_side, fill, drop, conflict;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state decode and per-cycle event strobes.
  always_comb begin
    state_d     = state_q;
    accept      = 1'b0;
    accept_side = 1'b0;
    fill        = 1'b0;
    drop        = 1'b0;
    conflict    = 1'b0;
    case (state_q)
      IDLE: begin
        if (buy_signal && sell_signal) begin
          conflict = 1'b1;
        end else if (buy_signal && (pos_q < POS_MAX)) begin
          accept  = 1'b1;
          state_d = SEND;
        end else if (sell_signal && (pos_q > POS_MIN)) begin
          accept      = 1'b1;
          accept_side = 1'b1;
          state_d     = SEND;
        end
      end
      SEND: begin
        // Ready on the final timeout cycle wins over the drop.
        if (order_ready)          fill = 1'b1;
        else if (wait_q == T_LAST) drop = 1'b1;
        if (fill || drop) state_d = (COOLDOWN_CYCLES == 0) ? IDLE : COOLDOWN;
      end
      COOLDOWN: begin
        if (cd_q == CD_LAST) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Order latch, timers, position and saturating statistics.
  always_ff @(posedge clk) begin
    if (rst) begin
      side_q     <= 1'b0;
      price_q    <= '0;
      pos_q      <= '0;
      wait_q     <= '0;
      cd_q       <= '0;
      fill_q     <= '0;
      timeout_q  <= '0;
      conflict_q <= '0;
    end else begin
      if (accept) begin
        side_q  <= accept_side;
        price_q <= price;
        wait_q  <= '0;
      end else if (state_q == SEND && !fill && !drop) begin
        wait_q <= wait_q + 8'd1;
      end
      if (state_q == SEND) cd_q <= '0;
      else if (state_q == COOLDOWN) cd_q <= cd_q + 8'd1;
      if (fill) begin
        pos_q <= side_q ? (pos_q - 8'sd1) : (pos_q + 8'sd1);
        if (fill_q != 8'hFF) fill_q <= fill_q + 8'd1;
      end
      if (drop && timeout_q != 8'hFF) timeout_q <= timeout_q + 8'd1;
      if (conflict && conflict_q != 8'hFF) conflict_q <= conflict_q + 8'd1;
    end
  end

  assign order_valid    = (state_q == SEND);
  assign busy           = (state_q != IDLE);
  assign order_side     = side_q;
  assign order_price    = price_q;
  assign position       = pos_q;
  assign fill_count     = fill_q;
  assign timeout_count  = timeout_q;
  assign conflict_count = conflict_q;

endmodule

// File: tb/tb_trade_order_ctrl.sv
// Directed self-checking bench for trade_order_ctrl (default parameters).
module tb_trade_order_ctrl;

  logic       clk = 1'b0;
  logic       rst, buy_signal, sell_signal, order_ready;
  logic [7:0] price;
  logic       order_valid, order_side, busy;
  logic [7:0] order_price, position, fill_count, timeout_count, conflict_count;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  int unsigned vcnt;

  trade_order_ctrl #(.MAX_POS(4), .COOLDOWN_CYCLES(8), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst), .buy_signal(buy_signal), .sell_signal(sell_signal),
    .price(price), .order_ready(order_ready), .order_valid(order_valid),
    .order_side(order_side), .order_price(order_price), .position(position),
    .busy(busy), .fill_count(fill_count), .timeout_count(timeout_count),
    .conflict_count(conflict_count)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled on the falling edge.
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_zero(input string tag);
    chk({tag, "_valid"}, 32'(order_valid), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_side"}, 32'(order_side), 0);
    chk({tag, "_price"}, 32'(order_price), 0);
    chk({tag, "_pos"}, 32'(position), 0);
    chk({tag, "_fill"}, 32'(fill_count), 0);
    chk({tag, "_tmo"}, 32'(timeout_count), 0);
    chk({tag, "_conf"}, 32'(conflict_count), 0);
  endtask

  initial begin
    rst = 1'b1; buy_signal = 1'b0; sell_signal = 1'b0; order_ready = 1'b0; price = 8'd0;
    tick(); tick();
    rst = 1'b0;
    chk_idle_zero("reset");

    // Single buy with ready tied high.
    buy_signal = 1'b1; price = 8'd100; order_ready = 1'b1;
    tick();
    buy_signal = 1'b0; price = 8'd0;
    chk("t1_valid", 32'(order_valid), 1);
    chk("t1_side", 32'(order_side), 0);
    chk("t1_price", 32'(order_price), 100);
    chk("t1_busy", 32'(busy), 1);
    tick();
    chk("t1_valid_off", 32'(order_valid), 0);
    chk("t1_pos", 32'(position), 1);
    chk("t1_fill", 32'(fill_count), 1);
    chk("t1_cd_busy", 32'(busy), 1);
    for (int i = 0; i < 7; i++) begin
      tick();
      chk("t1_cd_busy", 32'(busy), 1);
      chk("t1_cd_valid", 32'(order_valid), 0);
    end
    tick();
    chk("t1_idle", 32'(busy), 0);

    // Sell with ready held low: 16 valid cycles then drop.
    order_ready = 1'b0; sell_signal = 1'b1;
    tick();
    sell_signal = 1'b0;
    for (int i = 0; i < 16; i++) begin
      chk("t2_valid_hold", 32'(order_valid), 1);
      chk("t2_side", 32'(order_side), 1);
      tick();
    end
    chk("t2_valid_off", 32'(order_valid), 0);
    chk("t2_tmo", 32'(timeout_count), 1);
    chk("t2_pos", 32'(position), 1);
    chk("t2_fill", 32'(fill_count), 1);
    for (int i = 0; i < 7; i++) begin
      tick();
      chk("t2_cd_busy", 32'(busy), 1);
    end
    tick();
    chk("t2_idle", 32'(busy), 0);

    // Fresh start: buy held continuously, fills stop at the limit.
    rst = 1'b1; tick(); rst = 1'b0;
    chk_idle_zero("reset2");
    order_ready = 1'b1; buy_signal = 1'b1; price = 8'd20;
    vcnt = 0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (order_valid) vcnt++;
    end
    buy_signal = 1'b0;
    chk("t3_orders", vcnt, 4);
    chk("t3_pos", 32'(position), 4);
    chk("t3_fill", 32'(fill_count), 4);
    chk("t3_busy", 32'(busy), 0);
    sell_signal = 1'b1; price = 8'd33;
    tick();
    sell_signal = 1'b0;
    chk("t3_sell_valid", 32'(order_valid), 1);
    chk("t3_sell_side", 32'(order_side), 1);
    chk("t3_sell_price", 32'(order_price), 33);
    tick();
    chk("t3_sell_pos", 32'(position), 3);
    chk("t3_sell_fill", 32'(fill_count), 5);
    for (int i = 0; i < 8; i++) tick();
    chk("t3_idle", 32'(busy), 0);

    // Both signals high for three IDLE cycles.
    buy_signal = 1'b1; sell_signal = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t4_valid", 32'(order_valid), 0);
      chk("t4_busy", 32'(busy), 0);
    end
    buy_signal = 1'b0; sell_signal = 1'b0;
    chk("t4_conf", 32'(conflict_count), 3);
    chk("t4_pos", 32'(position), 3);

    // Ready on SEND cycle 5 while price moves every cycle.
    order_ready = 1'b0; buy_signal = 1'b1; price = 8'd50;
    tick();
    buy_signal = 1'b0;
    for (int i = 0; i < 4; i++) begin
      price = price + 8'd7;
      chk("t5_valid", 32'(order_valid), 1);
      chk("t5_price", 32'(order_price), 50);
      tick();
    end
    order_ready = 1'b1; price = price + 8'd7;
    chk("t5_valid5", 32'(order_valid), 1);
    chk("t5_price5", 32'(order_price), 50);
    tick();
    order_ready = 1'b0;
    chk("t5_valid_off", 32'(order_valid), 0);
    chk("t5_fill", 32'(fill_count), 6);
    chk("t5_pos", 32'(position), 4);
    chk("t5_tmo", 32'(timeout_count), 0);
    for (int i = 0; i < 8; i++) tick();
    chk("t5_idle", 32'(busy), 0);

    // Reset on SEND cycle 3, then a normal buy (position back to 0 allows it).
    sell_signal = 1'b1; price = 8'd77;
    tick();
    sell_signal = 1'b0;
    chk("t6_valid", 32'(order_valid), 1);
    tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_idle_zero("t6_rst");
    order_ready = 1'b1; buy_signal = 1'b1; price = 8'd9;
    tick();
    buy_signal = 1'b0;
    chk("t6_buy_valid", 32'(order_valid), 1);
    chk("t6_buy_price", 32'(order_price), 9);
    tick();
    chk("t6_buy_pos", 32'(position), 1);
    chk("t6_buy_fill", 32'(fill_count), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
